// File: rtl/dodge_field_engine.sv
// dodge_field_engine
// ------------------
// Falling-obstacle playfield engine for the dodge game.
//
// The engine holds a ROWS x COLS occupancy field. While a game runs, the
// field drops by one row on every game tick. The engine also:
//   - tracks the player column on the bottom row,
//   - detects collisions between the player and obstacles,
//   - runs the IDLE / RUN / OVER game state machine,
//   - counts the steps survived as the score.
//
// Optional feature macro: SPAWN_LFSR_EN
//   Defined   : a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//               generates the spawned top row. spawn_row is ignored.
//   Undefined : spawn_row is loaded into the top row on each step.
//
// Ports:
//   CLK_50      in   1        system clock, all state on rising edge
//   RESET       in   1        synchronous active-high reset
//   start       in   1        pulse: begin / restart a game
//   move_left   in   1        pulse: move player one column left
//   move_right  in   1        pulse: move player one column right
//   spawn_row   in   COLS     pattern loaded into the top row on each step
//   rd_row      in   RA_W     display read row address (0 = top)
//   rd_data     out  COLS     field[rd_row], combinational; 0 when out of range
//   player_x    out  PX_W     player column on the bottom row
//   state       out  2        IDLE=0, RUN=1, OVER=2
//   end_game    out  1        high while in OVER
//   score       out  SCORE_W  steps survived
//   step        out  1        one-cycle pulse on each drop step
module dodge_field_engine #(
  parameter  int COLS     = 10,
  parameter  int ROWS     = 20,
  parameter  int TICK_DIV = 5000000,
  parameter  int SCORE_W  = 16,
  localparam int PX_W     = $clog2(COLS),
  localparam int RA_W     = $clog2(ROWS)
) (
  input  logic               CLK_50,
  input  logic               RESET,
  input  logic               start,
  input  logic               move_left,
  input  logic               move_right,
  input  logic [COLS-1:0]    spawn_row,
  input  logic [RA_W-1:0]    rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic [PX_W-1:0]    player_x,
  output logic [1:0]         state,
  output logic               end_game,
  output logic [SCORE_W-1:0] score,
  output logic               step
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [PX_W-1:0]  X_MID    = PX_W'(COLS / 2);
  localparam logic [PX_W-1:0]  X_MAX    = PX_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [RA_W:0]    ROWS_L   = (RA_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [COLS-1:0]  field      [ROWS];
  logic [COLS-1:0]  next_field [ROWS];
  logic [PX_W-1:0]  next_x;
  logic [CNT_W-1:0] tick_cnt;
  logic [COLS-1:0]  spawn_src;
  logic             step_c;
  logic             collide;

  // A drop step happens only while running, on the last count of the divider.
  assign step_c = (cur_state == RUN) && (tick_cnt == CNT_LAST);

`ifdef SPAWN_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [31:0] lfsr_mod;

  // Spawn row is derived from the LFSR value after this step's advance:
  // a single obstacle at column (lfsr[7:0] mod COLS), present only when bit 8 is set.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    lfsr_mod  = {24'd0, lfsr_next[7:0]} % 32'(COLS);
    spawn_src = '0;
    spawn_src[lfsr_mod[PX_W-1:0]] = lfsr_next[8];
  end

  // The LFSR is reseeded on reset and whenever a new game begins,
  // and advances once per drop step.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      lfsr <= 16'hACE1;
    end else if ((cur_state != RUN) && start) begin
      lfsr <= 16'hACE1;
    end else if (step_c) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign spawn_src = spawn_row;
`endif

  // Next player column.
  // A lone left or right request moves the player, saturating at the edges.
  // Simultaneous requests cancel.
  always_comb begin
    next_x = player_x;
    if (move_left && !move_right && (player_x != '0)) begin
      next_x = player_x - 1'b1;
    end else if (move_right && !move_left && (player_x != X_MAX)) begin
      next_x = player_x + 1'b1;
    end
  end

  // Next field contents.
  // On a step the whole field shifts down one row, the bottom row falls off,
  // and the spawn pattern enters at the top.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      next_field[i] = field[i];
    end
    if (step_c) begin
      next_field[0] = spawn_src;
      for (int i = 1; i < ROWS; i++) begin
        next_field[i] = field[i-1];
      end
    end
  end

  // The collision test uses the post-update field and player position.
  // This catches both an obstacle landing on the player and the player
  // stepping into an occupied cell.
  assign collide = (cur_state == RUN) && next_field[ROWS-1][next_x];

  // State register.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic.
  // start is only honoured outside RUN.
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE:    if (start)   nxt_state = RUN;
      RUN:     if (collide) nxt_state = OVER;
      OVER:    if (start)   nxt_state = RUN;
      default: nxt_state = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    end_game = (cur_state == OVER);
    step     = step_c;
  end

  assign state = cur_state;

  // Playfield datapath.
  // Everything is frozen outside RUN, except for the clear that happens
  // when a new game starts.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      for (int i = 0; i < ROWS; i++) begin
        field[i] <= '0;
      end
      player_x <= X_MID;
      score    <= '0;
      tick_cnt <= '0;
    end else if (cur_state == RUN) begin
      for (int i = 0; i < ROWS; i++) begin
        field[i] <= next_field[i];
      end
      player_x <= next_x;
      if (tick_cnt == CNT_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (step_c && !collide && !(&score)) begin
        score <= score + 1'b1;
      end
    end else if (start) begin
      for (int i = 0; i < ROWS; i++) begin
        field[i] <= '0;
      end
      player_x <= X_MID;
      score    <= '0;
      tick_cnt <= '0;
    end
  end

  // Display read port.
  // Addresses at or beyond ROWS read as empty.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_row} < ROWS_L) begin
      rd_data = field[rd_row];
    end
  end

endmodule

// File: tb/tb_dodge_field_engine.sv
// tb_dodge_field_engine
// ---------------------
// Directed testbench for dodge_field_engine.
// Configuration: COLS=10, ROWS=20, TICK_DIV=4, LFSR spawn disabled.
//
// Inputs are driven on falling edges and outputs are sampled on falling
// edges, so every observation sees settled values after the preceding
// rising edge.
module tb_dodge_field_engine;

  localparam int COLS     = 10;
  localparam int ROWS     = 20;
  localparam int TICK_DIV = 4;
  localparam int SCORE_W  = 16;
  localparam int PX_W     = $clog2(COLS);
  localparam int RA_W     = $clog2(ROWS);

  logic               CLK_50;
  logic               RESET;
  logic               start;
  logic               move_left;
  logic               move_right;
  logic [COLS-1:0]    spawn_row;
  logic [RA_W-1:0]    rd_row;
  logic [COLS-1:0]    rd_data;
  logic [PX_W-1:0]    player_x;
  logic [1:0]         state;
  logic               end_game;
  logic [SCORE_W-1:0] score;
  logic               step;

  int num_checks;
  int num_errors;

  dodge_field_engine #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .TICK_DIV (TICK_DIV),
    .SCORE_W  (SCORE_W)
  ) dut (
    .CLK_50     (CLK_50),
    .RESET      (RESET),
    .start      (start),
    .move_left  (move_left),
    .move_right (move_right),
    .spawn_row  (spawn_row),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .player_x   (player_x),
    .state      (state),
    .end_game   (end_game),
    .score      (score),
    .step       (step)
  );

  // 10 ns clock.
  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  // Compare one observed value against its expected value and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold the given control inputs high for one clock cycle, then release them.
  task automatic applyStimulus(input logic l, input logic r, input logic s);
    move_left  = l;
    move_right = r;
    start      = s;
    @(negedge CLK_50);
    move_left  = 1'b0;
    move_right = 1'b0;
    start      = 1'b0;
  endtask

  // Wait for the next step pulse, with a bounded number of cycles,
  // and let that step commit.
  task automatic doStep();
    int n;
    n = 0;
    while (step !== 1'b1 && n < 8) begin
      @(negedge CLK_50);
      n++;
    end
    if (step !== 1'b1) checkOutput("step_timeout", 32'(step), 32'd1);
    @(negedge CLK_50);
  endtask

  // Check that every field row, and one out-of-range address, reads as zero.
  task automatic checkFieldClear(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      rd_row = RA_W'(r);
      #1;
      checkOutput($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'd0);
    end
    rd_row = 5'd31;
    #1;
    checkOutput($sformatf("%s_row31", tag), 32'(rd_data), 32'd0);
  endtask

  task automatic pulseReset();
    RESET = 1'b1;
    @(negedge CLK_50);
    @(negedge CLK_50);
    RESET = 1'b0;
  endtask

  initial begin
    int step_seen;
    num_checks = 0;
    num_errors = 0;
    RESET      = 1'b0;
    start      = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    spawn_row  = '0;
    rd_row     = '0;
    @(negedge CLK_50);

    // ---------------- Scenario 1: reset state ----------------
    pulseReset();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_px", 32'(player_x), 32'd5);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_end", 32'(end_game), 32'd0);
    checkFieldClear("rst");
    step_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK_50);
      if (step === 1'b1) step_seen++;
    end
    checkOutput("idle_no_step", 32'(step_seen), 32'd0);
    checkOutput("idle_state", 32'(state), 32'd0);

    // ---------------- Scenario 2: collision by drop ----------------
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_state", 32'(state), 32'd1);
    spawn_row = 10'h020;
    doStep();
    spawn_row = '0;
    rd_row = 5'd0;
    #1;
    checkOutput("drop_row0", 32'(rd_data), 32'h020);
    checkOutput("drop_score1", 32'(score), 32'd1);
    for (int k = 2; k <= 19; k++) doStep();
    rd_row = 5'd18;
    #1;
    checkOutput("drop_row18", 32'(rd_data), 32'h020);
    checkOutput("drop_score19", 32'(score), 32'd19);
    checkOutput("drop_state_run", 32'(state), 32'd1);
    doStep();
    checkOutput("hit_state", 32'(state), 32'd2);
    checkOutput("hit_end", 32'(end_game), 32'd1);
    checkOutput("hit_score", 32'(score), 32'd19);
    rd_row = 5'd19;
    #1;
    checkOutput("hit_row19", 32'(rd_data), 32'h020);
    rd_row = 5'd31;
    #1;
    checkOutput("oob_row31", 32'(rd_data), 32'd0);
    // Frozen in OVER: no steps, moves ignored, field and score held.
    step_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK_50);
      if (step === 1'b1) step_seen++;
    end
    checkOutput("over_no_step", 32'(step_seen), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("over_px_frozen", 32'(player_x), 32'd5);
    checkOutput("over_score_frozen", 32'(score), 32'd19);
    rd_row = 5'd19;
    #1;
    checkOutput("over_row19_frozen", 32'(rd_data), 32'h020);

    // ---------------- Scenario 6a: restart from OVER ----------------
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("restart_state", 32'(state), 32'd1);
    checkOutput("restart_end", 32'(end_game), 32'd0);
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_px", 32'(player_x), 32'd5);
    checkFieldClear("restart");

    // ---------------- Scenario 3: dodge ----------------
    spawn_row = 10'h020;
    doStep();
    spawn_row = '0;
    for (int k = 2; k <= 19; k++) doStep();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dodge_px", 32'(player_x), 32'd6);
    doStep();
    checkOutput("dodge_state20", 32'(state), 32'd1);
    rd_row = 5'd19;
    #1;
    checkOutput("dodge_row19", 32'(rd_data), 32'h020);
    for (int k = 21; k <= 25; k++) doStep();
    checkOutput("dodge_score25", 32'(score), 32'd25);
    checkOutput("dodge_state25", 32'(state), 32'd1);
    // start while running is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_start_state", 32'(state), 32'd1);
    checkOutput("run_start_score", 32'(score), 32'd25);
    checkOutput("run_start_px", 32'(player_x), 32'd6);

    // ---------------- Scenario 4: saturation and simultaneous moves ----------------
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_left", 32'(player_x), 32'd0);
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sat_right", 32'(player_x), 32'd9);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_moves", 32'(player_x), 32'd9);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("back_to_5", 32'(player_x), 32'd5);
    checkOutput("sat_state", 32'(state), 32'd1);

    // ---------------- Scenario 5: collision by move ----------------
    spawn_row = 10'h040;
    doStep();
    spawn_row = '0;
    for (int k = 2; k <= 20; k++) doStep();
    checkOutput("move_pre_state", 32'(state), 32'd1);
    rd_row = 5'd19;
    #1;
    checkOutput("move_row19", 32'(rd_data), 32'h040);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("move_hit_state", 32'(state), 32'd2);
    checkOutput("move_hit_end", 32'(end_game), 32'd1);
    checkOutput("move_hit_px", 32'(player_x), 32'd6);

    // ---------------- Scenario 6b: reset mid-RUN ----------------
    applyStimulus(1'b0, 1'b0, 1'b1);
    spawn_row = 10'h3FF;
    doStep();
    doStep();
    spawn_row = '0;
    checkOutput("mid_score", 32'(score), 32'd2);
    pulseReset();
    checkOutput("midrst_state", 32'(state), 32'd0);
    checkOutput("midrst_px", 32'(player_x), 32'd5);
    checkOutput("midrst_score", 32'(score), 32'd0);
    checkOutput("midrst_end", 32'(end_game), 32'd0);
    checkOutput("midrst_step", 32'(step), 32'd0);
    checkFieldClear("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
    $finish;
  end

  // Global time limit, so the bench always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
